welford_window_scheduler: RTL

//  Time-multiplexes one shared Welford variance engine between NUM_CH sample channels.

---
 rtl/welford_window_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/welford_window_scheduler.sv
// welford_window_scheduler
// Shares one Welford variance engine between NUM_CH sample channels. Each grant
// covers a whole window: clear the engine, stream WIN_LEN samples, wait for
// done, hand back the tagged variance, then re-arbitrate round-robin.
// Optional feature macro: WVS_TIMEOUT_EN (DRAIN watchdog, sticky err_to).
module welford_window_scheduler #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned WIN_LEN = 128,
  parameter int unsigned DONE_TO = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*16-1:0]   in_data,
  input  logic [NUM_CH-1:0]      in_valid,
  output logic [NUM_CH-1:0]      in_ready,
  output logic                   eng_clr,
  output logic                   eng_valid,
  output logic [15:0]            eng_data,
  input  logic                   eng_done,
  input  logic [31:0]            eng_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic [CH_W-1:0]        res_ch,
  output logic                   busy,
  output logic                   err_to
);

  typedef enum logic [2:0] {IDLE, ARB, CLEAR, STREAM, DRAIN, REPORT} state_t;

  localparam int unsigned CNT_W = $clog2(WIN_LEN);

  if (CH_W != $clog2(NUM_CH) || NUM_CH < 2 || WIN_LEN < 2 || DONE_TO < 1) begin : g_bad_cfg
    $error("welford_window_scheduler: inconsistent parameters");
  end

  state_t            state, state_nxt;
  logic [CH_W-1:0]   rr_ptr, cur_ch, grant, grant_inc;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       sample;
  logic              found, xfer, last, to_hit;
  int unsigned       idx;

  // Round-robin search: first requesting channel at or above rr_ptr, with wrap
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = CH_W'(idx);
      end
    end
  end

  assign grant_inc = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;

  // Granted-channel sample mux and one-hot ready while streaming
  always_comb begin
    sample   = '0;
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cur_ch == CH_W'(i)) begin
        sample      = in_data[16*i +: 16];
        in_ready[i] = (state == STREAM);
      end
    end
  end

  assign xfer    = (state == STREAM) && |(in_valid & in_ready);
  assign last    = (cnt == CNT_W'(WIN_LEN - 1));
  assign eng_clr = (state == CLEAR);
  assign busy    = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|in_valid) state_nxt = ARB;
      ARB:     state_nxt = found ? CLEAR : IDLE;
      CLEAR:   state_nxt = STREAM;
      STREAM:  if (xfer && last) state_nxt = DRAIN;
      DRAIN: begin
        if (eng_done)    state_nxt = REPORT;
        else if (to_hit) state_nxt = ARB;
      end
      REPORT:  if (res_ready) state_nxt = ARB;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping, window counter, engine strobe and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      cur_ch    <= '0;
      cnt       <= '0;
      eng_valid <= 1'b0;
      eng_data  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ch    <= '0;
    end else begin
      eng_valid <= xfer;
      if (xfer) eng_data <= sample;
      case (state)
        ARB: begin
          if (found) begin
            cur_ch <= grant;
            rr_ptr <= grant_inc;
          end
        end
        CLEAR:  cnt <= '0;
        STREAM: if (xfer && !last) cnt <= cnt + 1'b1;
        DRAIN: begin
          if (eng_done) begin
            res_data  <= eng_result;
            res_ch    <= cur_ch;
            res_valid <= 1'b1;
          end
        end
        REPORT: if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef WVS_TIMEOUT_EN
  localparam int unsigned TO_W = (DONE_TO > 1) ? $clog2(DONE_TO) : 1;

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  assign to_hit = (state == DRAIN) && !eng_done && (to_cnt == TO_W'(DONE_TO - 1));
  assign err_to = err_q;

  // DRAIN watchdog: counter held at 0 outside DRAIN, sticky error on expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else if (state != DRAIN) begin
      to_cnt <= '0;
    end else if (!eng_done) begin
      if (to_hit) err_q  <= 1'b1;
      else        to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err_to = 1'b0;
`endif

endmodule
